// File: rtl/ex_pkg.sv
// Shared execute-stage encodings: ALU ops, branch ops, mul/div ops, FSM states.
// Latency: n/a (types only).
// Backpressure: n/a.
package ex_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        BRU_EQ  = 3'd0,
        BRU_NE  = 3'd1,
        BRU_LT  = 3'd4,
        BRU_GE  = 3'd5,
        BRU_LTU = 3'd6,
        BRU_GEU = 3'd7
    } bru_op_e;

    typedef enum logic [2:0] {
        MD_MUL   = 3'd0,
        MD_MULH  = 3'd1,
        MD_MULHU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_REM   = 3'd5,
        MD_REMU  = 3'd6,
        MD_NONE  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle on magnitudes.
// Latency: XLEN cycles from start; done pulses with result valid in the final cycle.
// Backpressure: none; caller captures result on done, abort cancels at any time.
module muldiv_iter
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    logic            busy;
    logic [CW-1:0]   cnt;
    logic [2:0]      op_q;
    logic [2*XLEN-1:0] acc, acc_nxt, prod;
    logic [XLEN-1:0] opnd, a_q;
    logic            a_neg_q, b_neg_q, b_zero_q;

    logic            sgn_op, mul_op, a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs, quo, rem;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;

    // Sign handling at start: only MULH/DIV/REM treat operands as signed.
    always_comb begin
        sgn_op = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
        mul_op = (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHU);
        a_neg  = sgn_op && a[XLEN-1];
        b_neg  = sgn_op && b[XLEN-1];
        a_abs  = a_neg ? -a : a;
        b_abs  = b_neg ? -b : b;
    end

    // One iteration: mul adds multiplicand into the high half and shifts right;
    // div shifts remainder:quotient left and subtracts the divisor when it fits.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (op_q <= MD_MULHU)
            acc_nxt = {mul_sum, acc[XLEN-1:1]};
        else if (!div_diff[XLEN])
            acc_nxt = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            acc_nxt = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end

    assign done = busy && (cnt == CW'(XLEN - 1));

    // Result is formed from the post-final-step value so it is ready in the done cycle.
    always_comb begin
        prod   = (a_neg_q ^ b_neg_q) ? -acc_nxt : acc_nxt;
        quo    = acc_nxt[XLEN-1:0];
        rem    = acc_nxt[2*XLEN-1:XLEN];
        result = '0;
        case (op_q)
            MD_MUL:   result = prod[XLEN-1:0];
            MD_MULH:  result = prod[2*XLEN-1:XLEN];
            MD_MULHU: result = prod[2*XLEN-1:XLEN];
            MD_DIV:   result = b_zero_q ? '1 : ((a_neg_q ^ b_neg_q) ? -quo : quo);
            MD_DIVU:  result = b_zero_q ? '1 : quo;
            MD_REM:   result = b_zero_q ? a_q : (a_neg_q ? -rem : rem);
            MD_REMU:  result = b_zero_q ? a_q : rem;
            default:  result = '0;
        endcase
    end

    // Operand capture on start, then one step per cycle until done or abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            cnt      <= '0;
            op_q     <= '0;
            acc      <= '0;
            opnd     <= '0;
            a_q      <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
        end else if (abort) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            cnt      <= '0;
            op_q     <= op;
            a_q      <= a;
            a_neg_q  <= a_neg;
            b_neg_q  <= b_neg;
            b_zero_q <= (b == '0);
            opnd     <= mul_op ? a_abs : b_abs;
            acc      <= {{XLEN{1'b0}}, (mul_op ? b_abs : a_abs)};
        end else if (busy) begin
            acc <= acc_nxt;
            cnt <= done ? '0 : cnt + 1'b1;
            if (done)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/ex_stage_mc.sv
// Multi-cycle execute stage: forwarding, ALU/BRU in one cycle, iterative mul/div.
// Latency: 1 cycle for ALU/branch ops, XLEN+1 cycles for mul/div.
// Backpressure: outputs hold while out_ready=0; in_ready drops while busy or stalled.
module ex_stage_mc
    import ex_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NFWD = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [XLEN-1:0]      rs1_data,
    input  logic [XLEN-1:0]      rs2_data,
    input  logic [XLEN-1:0]      imm,
    input  logic [XLEN-1:0]      pc,
    input  logic                 alu_src,
    input  logic [3:0]           alu_op,
    input  logic [2:0]           bru_op,
    input  logic                 branch,
    input  logic                 md_en,
    input  logic [2:0]           md_op,
    input  logic [NFWD*5-1:0]    fwd_rd,
    input  logic [NFWD-1:0]      fwd_we,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      result,
    output logic                 branch_taken,
    output logic [XLEN-1:0]      branch_target
);
    localparam int SHW = $clog2(XLEN);

    state_e          state, state_nxt;
    logic [NFWD-1:0] hit_a, hit_b;
    logic [XLEN-1:0] src_a, src_b, alu_b, alu_res, md_result;
    logic [SHW-1:0]  shamt;
    logic            br_take, accept, md_done;

    // Per-source match; x0 never matches so it always reads as zero.
    for (genvar k = 0; k < NFWD; k++) begin : g_fwd
        assign hit_a[k] = fwd_we[k] && (rs1 != 5'd0) && (fwd_rd[k*5 +: 5] == rs1);
        assign hit_b[k] = fwd_we[k] && (rs2 != 5'd0) && (fwd_rd[k*5 +: 5] == rs2);
    end

    // Priority select: walk oldest to youngest so the lowest index wins.
    always_comb begin
        src_a = rs1_data;
        src_b = rs2_data;
        for (int k = NFWD - 1; k >= 0; k--) begin
            if (hit_a[k]) src_a = fwd_data[k*XLEN +: XLEN];
            if (hit_b[k]) src_b = fwd_data[k*XLEN +: XLEN];
        end
    end

    // ALU; operand B may be the immediate, branch compare always uses rs2.
    always_comb begin
        alu_b   = alu_src ? imm : src_b;
        shamt   = alu_b[SHW-1:0];
        alu_res = '0;
        case (alu_op)
            ALU_ADD:  alu_res = src_a + alu_b;
            ALU_SUB:  alu_res = src_a - alu_b;
            ALU_SLL:  alu_res = src_a << shamt;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(alu_b)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, src_a < alu_b};
            ALU_XOR:  alu_res = src_a ^ alu_b;
            ALU_SRL:  alu_res = src_a >> shamt;
            ALU_SRA:  alu_res = $signed(src_a) >>> shamt;
            ALU_OR:   alu_res = src_a | alu_b;
            ALU_AND:  alu_res = src_a & alu_b;
            default:  alu_res = '0;
        endcase
    end

    // Branch resolution unit.
    always_comb begin
        br_take = 1'b0;
        case (bru_op)
            BRU_EQ:  br_take = (src_a == src_b);
            BRU_NE:  br_take = (src_a != src_b);
            BRU_LT:  br_take = ($signed(src_a) < $signed(src_b));
            BRU_GE:  br_take = ($signed(src_a) >= $signed(src_b));
            BRU_LTU: br_take = (src_a < src_b);
            BRU_GEU: br_take = (src_a >= src_b);
            default: br_take = 1'b0;
        endcase
    end

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready && !flush;

    muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && md_en),
        .abort  (flush),
        .op     (md_op),
        .a      (src_a),
        .b      (src_b),
        .done   (md_done),
        .result (md_result)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: single-cycle ops never leave IDLE; flush always wins.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && md_en) state_nxt = BUSY;
            BUSY:    if (md_done)         state_nxt = DONE;
            DONE:    if (out_ready)       state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // Output register: load on ALU accept or mul/div completion, drop on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            result        <= '0;
            branch_taken  <= 1'b0;
            branch_target <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept && !md_en) begin
            out_valid     <= 1'b1;
            result        <= alu_res;
            branch_taken  <= branch && br_take;
            branch_target <= pc + imm;
        end else if (state == BUSY && md_done) begin
            out_valid    <= 1'b1;
            result       <= md_result;
            branch_taken <= 1'b0;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage_mc.sv
module tb_ex_stage_mc;
    localparam int XLEN = 32;
    localparam int NFWD = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, in_ready, alu_src, branch, md_en, flush;
    logic        out_valid, out_ready, branch_taken;
    logic [4:0]  rs1, rs2;
    logic [31:0] rs1_data, rs2_data, imm, pc, result, branch_target;
    logic [3:0]  alu_op;
    logic [2:0]  bru_op, md_op;
    logic [9:0]  fwd_rd;
    logic [1:0]  fwd_we;
    logic [63:0] fwd_data;

    int checks = 0;
    int failures = 0;

    ex_stage_mc #(.XLEN(XLEN), .NFWD(NFWD)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .imm(imm), .pc(pc), .alu_src(alu_src), .alu_op(alu_op), .bru_op(bru_op),
        .branch(branch), .md_en(md_en), .md_op(md_op), .fwd_rd(fwd_rd),
        .fwd_we(fwd_we), .fwd_data(fwd_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .branch_taken(branch_taken),
        .branch_target(branch_target)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] fwd_val(input logic [4:0] r, input logic [31:0] rf);
        if (r == 5'd0) return rf;
        for (int k = 0; k < NFWD; k++)
            if (fwd_we[k] && fwd_rd[k*5 +: 5] == r) return fwd_data[k*32 +: 32];
        return rf;
    endfunction

    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = $signed(a);
        longint sh;
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a << b[4:0];
            4'd3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4: return (a < b) ? 32'd1 : 32'd0;
            4'd5: return a ^ b;
            4'd6: return a >> b[4:0];
            4'd7: begin sh = sa / (longint'(1) << b[4:0]); if (sa < 0 && sa % (longint'(1) << b[4:0]) != 0) sh = sh - 1; return sh[31:0]; end
            4'd8: return a | b;
            4'd9: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic br_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] md_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = $signed(a);
        longint sb = $signed(b);
        logic [63:0] ua = {32'd0, a};
        logic [63:0] ub = {32'd0, b};
        logic [63:0] p;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = ua * ub; return p[63:32]; end
            3'd3: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd5: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            3'd6: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic clear_inputs();
        in_valid = 0; rs1 = 0; rs2 = 0; rs1_data = 0; rs2_data = 0; imm = 0; pc = 0;
        alu_src = 0; alu_op = 0; bru_op = 0; branch = 0; md_en = 0; md_op = 0;
        fwd_rd = 0; fwd_we = 0; fwd_data = 0; flush = 0; out_ready = 1;
    endtask

    task automatic rand_alu_fields();
        rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
        rs1_data = $urandom; rs2_data = $urandom;
        if ($urandom_range(0, 3) == 0) rs2_data = rs1_data;
        imm = $urandom; pc = $urandom; alu_src = 1'($urandom_range(0, 1));
        alu_op = 4'($urandom_range(0, 9)); bru_op = 3'($urandom_range(0, 7));
        branch = 1'($urandom_range(0, 1)); md_en = 0;
        fwd_rd = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
        fwd_we = 2'($urandom_range(0, 3)); fwd_data = {$urandom, $urandom};
    endtask

    task automatic expect_alu(output logic [31:0] r, output logic t, output logic [31:0] g);
        logic [31:0] a, b;
        a = fwd_val(rs1, rs1_data);
        b = fwd_val(rs2, rs2_data);
        r = alu_model(alu_op, a, alu_src ? imm : b);
        t = branch ? br_model(bru_op, a, b) : 1'b0;
        g = pc + imm;
    endtask

    // Issues one mul/div op from idle and scrambles inputs while it runs.
    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output bit rdy_low, output logic tk);
        @(negedge clk);
        clear_inputs();
        md_en = 1; md_op = op; rs1 = 5'd1; rs2 = 5'd2; rs1_data = a; rs2_data = b;
        alu_src = 1; imm = $urandom; branch = 1; bru_op = 3'd1; in_valid = 1;
        lat = -1; rdy_low = 1; res = '0; tk = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i; res = result; tk = branch_taken; in_valid = 0;
                break;
            end
            if (in_ready) rdy_low = 0;
            rs1_data = $urandom; rs2_data = $urandom; md_op = 3'($urandom_range(0, 7));
            in_valid = 1'($urandom_range(0, 1));
        end
        in_valid = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
        checks++; if (branch_taken !== 1'b0) begin failures++; $display("FAIL reset_taken got=%b exp=0", branch_taken); end
        checks++; if (branch_target !== 32'd0) begin failures++; $display("FAIL reset_target got=%h exp=0", branch_target); end
        rst_n = 1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_forwarding();
        @(negedge clk);
        clear_inputs();
        rs1 = 5; rs1_data = 1; fwd_rd = {5'd5, 5'd5}; fwd_we = 2'b11; fwd_data = {32'd9, 32'd7};
        alu_op = 0; imm = 3; alu_src = 1; in_valid = 1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || result !== 32'd10) begin failures++; $display("FAIL fwd_priority vld=%b got=%h exp=0000000a", out_valid, result); end
        clear_inputs();
        rs1 = 0; rs1_data = 0; fwd_rd = {5'd0, 5'd0}; fwd_we = 2'b01; fwd_data = {32'd0, 32'hFFFF_FFFF};
        alu_op = 0; imm = 0; alu_src = 1; in_valid = 1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || result !== 32'd0) begin failures++; $display("FAIL fwd_x0 vld=%b got=%h exp=0", out_valid, result); end
        in_valid = 0;
    endtask

    task automatic test_alu_random();
        logic [31:0] er, eg;
        logic et;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            clear_inputs();
            rand_alu_fields();
            in_valid = 1;
            expect_alu(er, et, eg);
            @(negedge clk);
            in_valid = 0;
            checks++;
            if (out_valid !== 1'b1 || result !== er || branch_taken !== et || branch_target !== eg) begin
                failures++;
                $display("FAIL alu_rand[%0d] vld=%b res=%h/%h tk=%b/%b tgt=%h/%h", n, out_valid, result, er, branch_taken, et, branch_target, eg);
            end
        end
    endtask

    task automatic test_muldiv();
        logic [31:0] res, a, b;
        logic [31:0] pool [5];
        logic tk;
        logic [2:0] op;
        int lat;
        bit rl;
        run_md(3'd1, 32'hFFFF_FFFF, 32'd2, res, lat, rl, tk);
        checks++; if (res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mulh_result got=%h exp=ffffffff", res); end
        checks++; if (lat !== 33) begin failures++; $display("FAIL mulh_latency got=%0d exp=33", lat); end
        checks++; if (rl !== 1'b1) begin failures++; $display("FAIL mulh_in_ready_busy got=%b exp=1", rl); end
        checks++; if (tk !== 1'b0) begin failures++; $display("FAIL mulh_taken got=%b exp=0", tk); end
        pool = '{32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd7, 32'd1};
        for (int n = 0; n < 16; n++) begin
            op = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
            run_md(op, a, b, res, lat, rl, tk);
            checks++;
            if (res !== md_model(op, a, b) || lat !== 33) begin
                failures++;
                $display("FAIL md_rand op=%0d a=%h b=%h got=%h exp=%h lat=%0d", op, a, b, res, md_model(op, a, b), lat);
            end
        end
    endtask

    task automatic test_div_corner();
        logic [31:0] res;
        logic tk;
        int lat;
        bit rl;
        run_md(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, rl, tk);
        checks++; if (res !== 32'h8000_0000) begin failures++; $display("FAIL div_overflow got=%h exp=80000000", res); end
        run_md(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, rl, tk);
        checks++; if (res !== 32'd0) begin failures++; $display("FAIL rem_overflow got=%h exp=0", res); end
        run_md(3'd6, 32'd13, 32'd0, res, lat, rl, tk);
        checks++; if (res !== 32'd13) begin failures++; $display("FAIL remu_by_zero got=%h exp=d", res); end
        run_md(3'd4, 32'd13, 32'd0, res, lat, rl, tk);
        checks++; if (res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divu_by_zero got=%h exp=ffffffff", res); end
        run_md(3'd3, 32'hFFFF_FFF9, 32'd0, res, lat, rl, tk);
        checks++; if (res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_by_zero got=%h exp=ffffffff", res); end
        run_md(3'd5, 32'hFFFF_FFF9, 32'd0, res, lat, rl, tk);
        checks++; if (res !== 32'hFFFF_FFF9) begin failures++; $display("FAIL rem_by_zero got=%h exp=fffffff9", res); end
        run_md(3'd3, 32'hFFFF_FFF9, 32'd2, res, lat, rl, tk);
        checks++; if (res !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_neg got=%h exp=fffffffd", res); end
        run_md(3'd7, 32'd5, 32'd3, res, lat, rl, tk);
        checks++; if (res !== 32'd0) begin failures++; $display("FAIL md_code7 got=%h exp=0", res); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        clear_inputs();
        rs1 = 1; rs2 = 2; rs1_data = 100; rs2_data = 23; alu_op = 0; in_valid = 1;
        @(negedge clk);
        out_ready = 0;
        rs1_data = 5; rs2_data = 1; alu_op = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || result !== 32'd123 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d] vld=%b res=%h exp=0000007b in_ready=%b exp=0", i, out_valid, result, in_ready);
            end
        end
        out_ready = 1; in_valid = 0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release vld=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q [$];
        logic [31:0] er, eg;
        logic et;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1 || result !== exp_q[0]) begin
                    failures++;
                    $display("FAIL b2b[%0d] vld=%b got=%h exp=%h", i - 1, out_valid, result, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            if (i < 4) begin
                clear_inputs();
                rs1 = 5'd1; rs2 = 5'd2; rs1_data = $urandom; rs2_data = $urandom;
                imm = $urandom; alu_src = 1'($urandom_range(0, 1)); alu_op = 0; in_valid = 1;
                expect_alu(er, et, eg);
                exp_q.push_back(er);
                checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready[%0d] got=%b exp=1", i, in_ready); end
            end else begin
                in_valid = 0;
            end
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain vld=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        bit seen;
        @(negedge clk);
        clear_inputs();
        rs1 = 1; rs1_data = 4; imm = 4; alu_src = 1; in_valid = 1; flush = 1;
        @(negedge clk);
        flush = 0; in_valid = 0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL flush_accept vld=%b exp=0 in_ready=%b exp=1", out_valid, in_ready); end
        clear_inputs();
        rs1 = 1; rs2 = 2; rs1_data = 1000; rs2_data = 7; md_en = 1; md_op = 3'd3; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        repeat (9) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL flush_busy vld=%b exp=0 in_ready=%b exp=1", out_valid, in_ready); end
        seen = 0;
        repeat (40) begin @(negedge clk); if (out_valid) seen = 1; end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL flush_no_result seen=%b exp=0", seen); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge clk);
        clear_inputs();
        rs1 = 1; rs2 = 2; rs1_data = 5; rs2_data = 5; imm = 6; alu_src = 1; pc = 32'h100;
        branch = 1; bru_op = 3'd0; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        checks++;
        if (result !== 32'd11 || branch_taken !== 1'b1 || branch_target !== 32'h106) begin
            failures++;
            $display("FAIL pre_reset res=%h exp=b tk=%b exp=1 tgt=%h exp=106", result, branch_taken, branch_target);
        end
        @(negedge clk);
        clear_inputs();
        rs1 = 1; rs2 = 2; rs1_data = 99; rs2_data = 4; md_en = 1; md_op = 3'd3; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        repeat (5) @(negedge clk);
        #2 rst_n = 0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'd0 || branch_taken !== 1'b0 || branch_target !== 32'd0) begin
            failures++;
            $display("FAIL mid_reset vld=%b res=%h tk=%b tgt=%h exp all 0", out_valid, result, branch_taken, branch_target);
        end
        @(negedge clk);
        rst_n = 1;
        seen = 0;
        repeat (40) begin @(negedge clk); if (out_valid) seen = 1; end
        checks++; if (seen !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_after seen=%b exp=0 in_ready=%b exp=1", seen, in_ready); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst_n = 0;
        test_reset();
        test_forwarding();
        test_alu_random();
        test_muldiv();
        test_div_corner();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
